// File: rtl/muldiv_requester.sv
// muldiv_requester: host-side sequencer for a multiply/divide unit.
// Accepts one signed command at a time, launches it on the unit with a one-cycle
// op_start pulse, waits for a response (bounded by TIMEOUT cycles), and holds the
// result for the host until res_ready.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          host command handshake
//   cmd_a, cmd_b, cmd_sel        operands and operation (1 = multiply, 0 = divide)
//   op_a, op_b, op_sel, op_start operands, operation and launch pulse to the unit
//   op_busy, op_valid, op_error  unit status (op_busy is informational only)
//   op_m, op_r                   unit result (product hi/lo or quotient/remainder)
//   res_valid/res_ready          host result handshake
//   res_m, res_r                 captured result
//   res_err, res_timeout         error flag and timeout cause
//   err_count                    saturating count of errored results
module muldiv_requester #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_sel,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         op_sel,
  output logic         op_start,
  input  logic         op_busy,
  input  logic         op_valid,
  input  logic         op_error,
  input  logic [N-1:0] op_m,
  input  logic [N-1:0] op_r,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_m,
  output logic [N-1:0] res_r,
  output logic         res_err,
  output logic         res_timeout,
  output logic [7:0]   err_count
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  // op_busy carries no control meaning here.
  logic unused_busy;
  assign unused_busy = op_busy;

  logic          div_zero;
  logic          cnt_last;
  logic [7:0]    err_count_inc;

  assign cmd_ready     = (state_q == StIdle);
  assign div_zero      = !cmd_sel && (cmd_b == '0);
  // This WAIT cycle is the TIMEOUT-th one without a response.
  assign cnt_last      = (cnt_q == TimeoutVal - CW'(1));
  assign err_count_inc = (err_count == 8'hff) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_sel      <= 1'b0;
      op_start    <= 1'b0;
      res_valid   <= 1'b0;
      res_m       <= '0;
      res_r       <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      op_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_a   <= cmd_a;
            op_b   <= cmd_b;
            op_sel <= cmd_sel;
            if (div_zero) begin
              // Never launched: result is reported straight away.
              state_q     <= StHold;
              res_valid   <= 1'b1;
              res_m       <= '0;
              res_r       <= '0;
              res_err     <= 1'b1;
              res_timeout <= 1'b0;
              err_count   <= err_count_inc;
            end else begin
              state_q  <= StIssue;
              op_start <= 1'b1;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Priority: error, then valid result, then timeout.
          if (op_error) begin
            state_q     <= StHold;
            res_valid   <= 1'b1;
            res_m       <= '0;
            res_r       <= '0;
            res_err     <= 1'b1;
            res_timeout <= 1'b0;
            err_count   <= err_count_inc;
          end else if (op_valid) begin
            state_q     <= StHold;
            res_valid   <= 1'b1;
            res_m       <= op_m;
            res_r       <= op_r;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_last) begin
              state_q     <= StHold;
              res_valid   <= 1'b1;
              res_m       <= '0;
              res_r       <= '0;
              res_err     <= 1'b1;
              res_timeout <= 1'b1;
              err_count   <= err_count_inc;
            end
          end
        end
        StHold: begin
          if (res_ready) begin
            state_q   <= StIdle;
            res_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
